// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: ALU control encoding, register-zero constant
// and the ID/EXE stored-instruction record.
package mips_pkg;

    localparam int unsigned MIPS_DATA_W = 32;
    localparam int unsigned MIPS_REG_AW = 5;

    typedef logic [3:0] alu_ctrl_t;
    localparam alu_ctrl_t ALU_NOP = 4'b0000;

    localparam int unsigned REG_ZERO = 0;

    typedef struct packed {
        logic                   valid;
        logic [MIPS_REG_AW-1:0] rs_addr;
        logic [MIPS_REG_AW-1:0] rt_addr;
        logic [MIPS_REG_AW-1:0] rd_addr;
        logic [MIPS_DATA_W-1:0] rs_val;
        logic [MIPS_DATA_W-1:0] rt_val;
        logic [MIPS_DATA_W-1:0] imm;
        logic                   use_imm;
        alu_ctrl_t              ctrl;
        logic                   reg_write;
        logic                   mem_read;
    } issue_reg_t;

endpackage

// File: rtl/id_exe_issue_fwd_mux.sv
// Single-operand forwarding selector: MEM result over WB result over stored value.
// Only built when ISSUE_FWD_EN is defined.
`ifdef ISSUE_FWD_EN
module fwd_mux
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src_addr,
    input  logic [DATA_W-1:0] stored,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd_addr,
    input  logic [DATA_W-1:0] wb_result,
    output logic [DATA_W-1:0] operand
);

    logic src_nonzero;
    assign src_nonzero = (src_addr != REG_AW'(REG_ZERO));

    // Later assignment wins, giving MEM priority over WB.
    always_comb begin
        operand = stored;
        if (src_nonzero && wb_reg_write && (wb_rd_addr == src_addr))
            operand = wb_result;
        if (src_nonzero && mem_reg_write && (mem_rd_addr == src_addr))
            operand = mem_result;
    end

endmodule
`endif

// File: rtl/id_exe_issue.sv
// ID/EXE pipeline register and ALU operand issue with RAW hazard handling.
// Define ISSUE_FWD_EN for MEM/WB forwarding (load-use stall only); otherwise stall until the writer retires.
module id_exe_issue
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [REG_AW-1:0] id_rs_addr,
    input  logic [REG_AW-1:0] id_rt_addr,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic [DATA_W-1:0] id_rs_val,
    input  logic [DATA_W-1:0] id_rt_val,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_use_imm,
    input  logic [3:0]        id_alu_ctrl,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              flush,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd_addr,
    input  logic [DATA_W-1:0] wb_result,
    output logic              exe_valid,
    output logic [DATA_W-1:0] val1,
    output logic [DATA_W-1:0] val2,
    output logic [3:0]        control,
    output logic [REG_AW-1:0] exe_rd_addr,
    output logic              exe_reg_write,
    output logic              exe_mem_read
);

    issue_reg_t        q;
    issue_reg_t        id_entry;
    logic              hazard;
    logic              accept;
    logic [REG_AW-1:0] exe_rd;
    logic [DATA_W-1:0] rs_stored;
    logic [DATA_W-1:0] rt_stored;
    logic [DATA_W-1:0] imm_stored;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;

    function automatic logic src_hit(
        input logic              wr,
        input logic [REG_AW-1:0] wr_addr,
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rt,
        input logic              use_imm
    );
        return wr && (wr_addr != REG_AW'(REG_ZERO)) &&
               ((wr_addr == rs) || (!use_imm && (wr_addr == rt)));
    endfunction

    assign exe_rd     = REG_AW'(q.rd_addr);
    assign rs_stored  = DATA_W'(q.rs_val);
    assign rt_stored  = DATA_W'(q.rt_val);
    assign imm_stored = DATA_W'(q.imm);

    always_comb begin
`ifdef ISSUE_FWD_EN
        hazard = src_hit(q.valid && q.mem_read, exe_rd,
                         id_rs_addr, id_rt_addr, id_use_imm);
`else
        hazard = src_hit(q.valid && q.reg_write, exe_rd,
                         id_rs_addr, id_rt_addr, id_use_imm) ||
                 src_hit(mem_reg_write, mem_rd_addr,
                         id_rs_addr, id_rt_addr, id_use_imm) ||
                 src_hit(wb_reg_write, wb_rd_addr,
                         id_rs_addr, id_rt_addr, id_use_imm);
`endif
    end

    // Ready reflects the hazard only; flush squashes without affecting ready.
    assign id_ready = !hazard;
    assign accept   = id_valid && !hazard && !flush;

    always_comb begin
        id_entry           = '0;
        id_entry.valid     = 1'b1;
        id_entry.rs_addr   = MIPS_REG_AW'(id_rs_addr);
        id_entry.rt_addr   = MIPS_REG_AW'(id_rt_addr);
        id_entry.rd_addr   = MIPS_REG_AW'(id_rd_addr);
        id_entry.rs_val    = MIPS_DATA_W'(id_rs_val);
        id_entry.rt_val    = MIPS_DATA_W'(id_rt_val);
        id_entry.imm       = MIPS_DATA_W'(id_imm);
        id_entry.use_imm   = id_use_imm;
        id_entry.ctrl      = id_alu_ctrl;
        id_entry.reg_write = id_reg_write;
        id_entry.mem_read  = id_mem_read;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (accept) begin
            q <= id_entry;
        end else begin
            q.valid     <= 1'b0;
            q.reg_write <= 1'b0;
            q.mem_read  <= 1'b0;
            q.ctrl      <= ALU_NOP;
        end
    end

`ifdef ISSUE_FWD_EN
    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_a (
        .src_addr      (REG_AW'(q.rs_addr)),
        .stored        (rs_stored),
        .mem_reg_write (mem_reg_write),
        .mem_rd_addr   (mem_rd_addr),
        .mem_result    (mem_result),
        .wb_reg_write  (wb_reg_write),
        .wb_rd_addr    (wb_rd_addr),
        .wb_result     (wb_result),
        .operand       (opa)
    );

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_b (
        .src_addr      (REG_AW'(q.rt_addr)),
        .stored        (rt_stored),
        .mem_reg_write (mem_reg_write),
        .mem_rd_addr   (mem_rd_addr),
        .mem_result    (mem_result),
        .wb_reg_write  (wb_reg_write),
        .wb_rd_addr    (wb_rd_addr),
        .wb_result     (wb_result),
        .operand       (opb)
    );
`else
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{mem_result, wb_result, q.rs_addr, q.rt_addr};
    assign opa = rs_stored;
    assign opb = rt_stored;
`endif

    assign val1          = opa;
    assign val2          = q.use_imm ? imm_stored : opb;
    assign exe_valid     = q.valid;
    assign control       = q.ctrl;
    assign exe_rd_addr   = exe_rd;
    assign exe_reg_write = q.reg_write;
    assign exe_mem_read  = q.mem_read;

endmodule

// File: tb/tb_id_exe_issue.sv
// Self-checking bench for id_exe_issue: vector table plus hand-written hazard,
// flush and reset sequences; expectations flow through a scoreboard queue.
module tb_id_exe_issue;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_ready;
    logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
    logic [31:0] id_rs_val, id_rt_val, id_imm;
    logic        id_use_imm;
    logic [3:0]  id_alu_ctrl;
    logic        id_reg_write, id_mem_read, flush;
    logic        mem_reg_write, wb_reg_write;
    logic [4:0]  mem_rd_addr, wb_rd_addr;
    logic [31:0] mem_result, wb_result;
    logic        exe_valid, exe_reg_write, exe_mem_read;
    logic [31:0] val1, val2;
    logic [3:0]  control;
    logic [4:0]  exe_rd_addr;

    always #5 clk = ~clk;

    id_exe_issue #(.DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
        .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm),
        .id_use_imm(id_use_imm), .id_alu_ctrl(id_alu_ctrl),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
        .mem_reg_write(mem_reg_write), .mem_rd_addr(mem_rd_addr), .mem_result(mem_result),
        .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_result(wb_result),
        .exe_valid(exe_valid), .val1(val1), .val2(val2), .control(control),
        .exe_rd_addr(exe_rd_addr), .exe_reg_write(exe_reg_write), .exe_mem_read(exe_mem_read)
    );

    typedef struct {
        logic        valid;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rs_val, rt_val, imm;
        logic        use_imm;
        logic [3:0]  ctrl;
        logic        regw, memrd, flush;
        logic        mw;
        logic [4:0]  mrd;
        logic [31:0] mres;
        logic        ww;
        logic [4:0]  wrd;
        logic [31:0] wres;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic        rdy;
        logic [31:0] v1, v2;
    } vec_t;

    typedef struct {
        logic        valid;
        logic [31:0] v1, v2;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        regw, memrd;
    } exp_t;

    exp_t sb[$];
    vec_t vt[$];
    int   tests = 0;
    int   fails = 0;

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic stim_t op(input int unsigned rs, input int unsigned rsv,
                                 input int unsigned rt, input int unsigned rtv,
                                 input int unsigned rd, input int unsigned ctrl);
        stim_t s;
        s        = idle();
        s.valid  = 1'b1;
        s.rs     = 5'(rs);
        s.rs_val = rsv;
        s.rt     = 5'(rt);
        s.rt_val = rtv;
        s.rd     = 5'(rd);
        s.ctrl   = 4'(ctrl);
        s.regw   = 1'b1;
        return s;
    endfunction

    function automatic stim_t im(input stim_t s, input int unsigned imm);
        stim_t r;
        r         = s;
        r.use_imm = 1'b1;
        r.imm     = imm;
        return r;
    endfunction

    function automatic stim_t ld(input stim_t s);
        stim_t r;
        r       = s;
        r.memrd = 1'b1;
        return r;
    endfunction

    function automatic stim_t fl(input stim_t s);
        stim_t r;
        r       = s;
        r.flush = 1'b1;
        return r;
    endfunction

    function automatic stim_t fw(input stim_t s,
                                 input int unsigned mw, input int unsigned mrd, input int unsigned mres,
                                 input int unsigned ww, input int unsigned wrd, input int unsigned wres);
        stim_t r;
        r      = s;
        r.mw   = (mw != 0);
        r.mrd  = 5'(mrd);
        r.mres = mres;
        r.ww   = (ww != 0);
        r.wrd  = 5'(wrd);
        r.wres = wres;
        return r;
    endfunction

    function automatic vec_t vec(input stim_t s, input int unsigned rdy,
                                 input int unsigned v1, input int unsigned v2);
        vec_t v;
        v.s   = s;
        v.rdy = (rdy != 0);
        v.v1  = v1;
        v.v2  = v2;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input stim_t s);
        id_valid      = s.valid;
        id_rs_addr    = s.rs;
        id_rt_addr    = s.rt;
        id_rd_addr    = s.rd;
        id_rs_val     = s.rs_val;
        id_rt_val     = s.rt_val;
        id_imm        = s.imm;
        id_use_imm    = s.use_imm;
        id_alu_ctrl   = s.ctrl;
        id_reg_write  = s.regw;
        id_mem_read   = s.memrd;
        flush         = s.flush;
        mem_reg_write = s.mw;
        mem_rd_addr   = s.mrd;
        mem_result    = s.mres;
        wb_reg_write  = s.ww;
        wb_rd_addr    = s.wrd;
        wb_result     = s.wres;
    endtask

    task automatic chk_reset_state();
        chk("rst_exe_valid", 32'(exe_valid), 32'd0);
        chk("rst_control", 32'(control), 32'(ALU_NOP));
        chk("rst_reg_write", 32'(exe_reg_write), 32'd0);
        chk("rst_mem_read", 32'(exe_mem_read), 32'd0);
        chk("rst_rd_addr", 32'(exe_rd_addr), 32'd0);
        chk("rst_val1", val1, 32'd0);
        chk("rst_val2", val2, 32'd0);
        chk("rst_id_ready", 32'(id_ready), 32'd1);
    endtask

    // Drive one ID cycle, check ready, push the expected EXE content, then
    // pop and compare it after the capturing edge.
    task automatic step(input stim_t s, input int unsigned rdy,
                        input int unsigned v1, input int unsigned v2);
        exp_t e;
        apply(s);
        #1;
        chk("id_ready", 32'(id_ready), rdy);
        if (s.valid && (rdy != 0) && !s.flush)
            e = '{1'b1, v1, v2, s.ctrl, s.rd, s.regw, s.memrd};
        else
            e = '{1'b0, 32'd0, 32'd0, ALU_NOP, 5'd0, 1'b0, 1'b0};
        sb.push_back(e);
        @(posedge clk);
        #2;
        e = sb.pop_front();
        chk("exe_valid", 32'(exe_valid), 32'(e.valid));
        chk("control", 32'(control), 32'(e.ctrl));
        chk("exe_reg_write", 32'(exe_reg_write), 32'(e.regw));
        chk("exe_mem_read", 32'(exe_mem_read), 32'(e.memrd));
        if (e.valid) begin
            chk("val1", val1, e.v1);
            chk("val2", val2, e.v2);
            chk("exe_rd_addr", 32'(exe_rd_addr), 32'(e.rd));
        end
    endtask

    initial begin
        stim_t d;
        stim_t sub;

        vt.push_back(vec(op(1, 5, 2, 7, 3, 2), 1, 5, 7));
        vt.push_back(vec(im(op(5, 10, 6, 0, 7, 2), 'h100), 1, 10, 'h100));
        vt.push_back(vec(fl(op(8, 1, 9, 2, 10, 2)), 1, 0, 0));
        vt.push_back(vec(idle(), 1, 0, 0));
`ifdef ISSUE_FWD_EN
        vt.push_back(vec(fw(op(3, 'h11, 2, 'h22, 12, 3), 1, 3, 'hAA, 1, 3, 'hBB), 1, 'hAA, 'h22));
        vt.push_back(vec(fw(op(1, 1, 2, 2, 13, 3), 0, 0, 0, 1, 2, 'hBB), 1, 1, 'hBB));
`else
        vt.push_back(vec(fw(op(3, 'h11, 2, 'h22, 12, 3), 1, 3, 'hAA, 1, 3, 'hBB), 0, 0, 0));
        vt.push_back(vec(fw(op(1, 1, 2, 2, 13, 3), 0, 0, 0, 1, 2, 'hBB), 0, 0, 0));
`endif
        vt.push_back(vec(fw(op(0, 5, 0, 6, 14, 5), 1, 0, 'hCC, 1, 0, 'hDD), 1, 5, 6));
        vt.push_back(vec(fw(im(op(4, 'h40, 9, 0, 15, 6), 'h1234), 1, 9, 'hEE, 0, 0, 0), 1, 'h40, 'h1234));
`ifdef ISSUE_FWD_EN
        vt.push_back(vec(fw(op(1, 1, 6, 'h60, 16, 7), 1, 6, 'h66, 1, 6, 'h77), 1, 1, 'h66));
`else
        vt.push_back(vec(fw(op(1, 1, 6, 'h60, 16, 7), 1, 6, 'h66, 1, 6, 'h77), 0, 0, 0));
`endif
        vt.push_back(vec(op(1, 3, 2, 4, 17, 8), 1, 3, 4));
`ifdef ISSUE_FWD_EN
        vt.push_back(vec(op(17, 5, 2, 9, 18, 2), 1, 5, 9));
`else
        vt.push_back(vec(op(17, 5, 2, 9, 18, 2), 0, 0, 0));
`endif

        rst = 1'b1;
        apply(idle());
        @(posedge clk);
        #1;
        chk_reset_state();
        rst = 1'b0;

        for (int i = 0; i < vt.size(); i++)
            step(vt[i].s, 32'(vt[i].rdy), vt[i].v1, vt[i].v2);

        // Load-use: LW r4 then ADD reading r4.
        step(ld(im(op(1, 'h100, 0, 0, 4, 1), 4)), 1, 'h100, 4);
        d = op(4, 'h999, 2, 7, 5, 2);
        step(d, 0, 0, 0);
`ifdef ISSUE_FWD_EN
        step(fw(d, 1, 4, 'hDEAD, 0, 0, 0), 1, 'hDEAD, 7);
`else
        step(fw(d, 1, 4, 'hDEAD, 0, 0, 0), 0, 0, 0);
        step(fw(d, 0, 0, 0, 1, 4, 'hDEAD), 0, 0, 0);
        step(d, 1, 'h999, 7);
`endif

        // ALU producer r5 followed by dependent SUB.
        sub = op(5, 'h50, 3, 3, 6, 6);
`ifdef ISSUE_FWD_EN
        step(sub, 1, 'h50, 3);
        step(fw(op(6, 0, 1, 1, 7, 2), 1, 6, 'h77, 0, 0, 0), 1, 'h77, 1);
`else
        step(sub, 0, 0, 0);
        step(fw(sub, 1, 5, 'h1111, 0, 0, 0), 0, 0, 0);
        step(fw(sub, 0, 0, 0, 1, 5, 'h1111), 0, 0, 0);
        step(sub, 1, 'h50, 3);
`endif

        // Flush while ID is stalled on a load: bubble, then no duplicate.
        step(ld(im(op(1, 'h10, 0, 0, 8, 1), 4)), 1, 'h10, 4);
        step(fl(op(8, 0, 2, 0, 9, 2)), 0, 0, 0);
        step(op(2, 'h21, 3, 'h31, 10, 3), 1, 'h21, 'h31);
        step(idle(), 1, 0, 0);

        // Reset asserted mid-stall clears EXE at once; ID re-presents afterwards.
        step(ld(im(op(1, 'h30, 0, 0, 11, 1), 8)), 1, 'h30, 8);
        d = op(11, 'h44, 2, 'h55, 12, 2);
        apply(d);
        #1;
        chk("stall_id_ready", 32'(id_ready), 32'd0);
        #1;
        rst = 1'b1;
        #1;
        chk_reset_state();
        #1;
        rst = 1'b0;
        step(d, 1, 'h44, 'h55);
        step(idle(), 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
